dcr_bank: RTL and testbench
===========================

# dcr_bank

Parametrised device control register bank that replaces the single-register `dcr`. It holds `NUM_REGS` host-writable shadow registers, commits them atomically to an active copy on a kernel launch, and offers the launch to the dispatcher over a valid/ready handshake. It freezes the active copy while a kernel runs. The block sits between the host control interface and the dispatcher. Active register 0 drives `thread_count` exactly as the old `dcr` did.

## Interface
Parameters:
- `NUM_REGS`, 4: number of control registers (≥2).
- `DATA_W`, 8: register width.
- `ADDR_W`, `$clog2(NUM_REGS)`: address width. Derived; do not override.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled only on a `clk` rising edge.
- `device_control_write_enable` in 1: host write strobe.
- `device_control_addr` in ADDR_W+1: write/read address. The extra MSB allows out-of-range detection.
- `device_control_data` in DATA_W: write data.
- `rd_active` in 1: 0 reads the shadow copy, 1 reads the active copy.
- `rd_data` out DATA_W: registered read data.
- `launch_req` in 1: single-cycle host launch request.
- `launch_valid` out 1: launch offered to the dispatcher.
- `launch_ready` in 1: dispatcher accepts the launch.
- `kernel_done` in 1: single-cycle end-of-kernel pulse.
- `busy` out 1: high from the commit cycle through the kernel-done cycle.
- `active_regs` out NUM_REGS*DATA_W: flat active copy; register i occupies bits [i*DATA_W +: DATA_W].
- `thread_count` out DATA_W: active register 0.
- `err` out 2: sticky error flags. Bit 0 is a bad address. Bit 1 is a launch request while not IDLE.
- `err_clr` in 1: clears `err`.

## Operation
- Reset (`reset`=0 at a clock edge) has the following effects:
  - All shadow and active registers, `rd_data` and `err` go to 0.
  - The state goes to IDLE.
  - `launch_valid`=0 and `busy`=0.
  - Reset overrides everything, including a launch in progress.
- Write behaviour:
  - A write with `device_control_write_enable`=1 and addr < NUM_REGS updates that shadow register at the edge.
  - Writes are accepted in every state.
  - A write with addr ≥ NUM_REGS is dropped and sets `err[0]`.
- Read behaviour:
  - `rd_data` is updated every cycle from the shadow or active copy, selected by `rd_active`, for `device_control_addr`.
  - An out-of-range read address returns 0.
- FSM states and transitions:
  - IDLE: `launch_req` → COMMIT.
  - COMMIT (one cycle): all shadows are copied to the active copy; → OFFER.
  - OFFER: `launch_valid`=1; `launch_ready` → RUN.
  - RUN: wait; `kernel_done` → IDLE.
- `busy` = (state ≠ IDLE).
- A `launch_req` seen outside IDLE is ignored and sets `err[1]`.
- A `kernel_done` seen outside RUN is ignored.
- Simultaneous events:
  - Write and `launch_req` in the same IDLE cycle: the write lands in the shadow and is included in the commit.
  - Write during the COMMIT cycle: the commit copies the pre-write shadow value, and the write lands in the shadow for the next launch.
  - `err_clr` together with a new error event in the same cycle: set wins.
- `active_regs` and `thread_count` change only at the COMMIT edge and at reset.

## Timing
- Write-to-shadow latency is 1 cycle. Read latency is 1 cycle: `rd_data` is valid in the cycle after the address is presented.
- `launch_req` at edge N puts the state in COMMIT for cycle N+1. From edge N+1, `active_regs` holds the new values and the state is OFFER, with `launch_valid`=1 from cycle N+2.
- `launch_valid` stays high, with stable `active_regs`, until the cycle in which `launch_ready`=1. It falls on the next edge.
- `launch_ready` and `kernel_done` are sampled only in OFFER and RUN respectively. A `kernel_done` in the same cycle as the handshake is ignored.
- The fastest round trip is IDLE → COMMIT → OFFER (ready same cycle) → RUN (done next cycle) → IDLE, which takes 4 cycles.

## Structure
- `dcr_pkg`:
  - `dcr_state_e` enum {IDLE, COMMIT, OFFER, RUN}.
  - Error bit index constants `ERR_ADDR`=0 and `ERR_LAUNCH`=1.
- One sub-module, `dcr_launch_fsm`, holds the state register, the handshake and `busy`. It outputs a one-cycle `commit` strobe to the register array in `dcr_bank`.

## Test plan
- Reset with all inputs idle:
  - Expect `thread_count`=8'h00, `busy`=0, `launch_valid`=0 and `err`=0.
- Write 8'h55 to addr 0 and 8'h10 to addr 1, then read the shadow copy, then launch with `launch_ready` tied to 1:
  - The shadow reads return 8'h55 and 8'h10 one cycle after each address.
  - `thread_count`=8'h55 from the COMMIT edge.
  - `launch_valid` is high for one cycle.
- During RUN, write 8'h77 to addr 0:
  - The shadow reads 8'h77.
  - `thread_count` stays 8'h55 until `kernel_done` is followed by a new launch, after which it becomes 8'h77.
- Hold `launch_ready`=0 for 5 cycles in OFFER:
  - `launch_valid` stays high and `active_regs` stays stable.
  - A `launch_req` pulsed during OFFER sets `err[1]` and leaves the state unchanged.
- Write to addr NUM_REGS (4):
  - No register changes and `err[0]`=1.
  - `err_clr` returns `err` to 0.
- Write 8'h22 in the same cycle as `launch_req`: the commit includes 8'h22.
- Write 8'h33 during COMMIT: active stays 8'h22 and the shadow becomes 8'h33.
- Assert `reset`=0 in RUN:
  - At the next edge the state is IDLE, `busy`=0, and all registers are 0.

Source files
------------

// File: rtl/dcr_pkg.sv
// Shared types and constants for the device control register bank.
package dcr_pkg;

    // Launch sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        OFFER  = 2'd2,
        RUN    = 2'd3
    } dcr_state_e;

    // Sticky error flag layout.
    localparam int ERR_W      = 2;
    localparam int ERR_ADDR   = 0;  // write to an out-of-range address
    localparam int ERR_LAUNCH = 1;  // launch request while a launch is in flight

endpackage : dcr_pkg

// File: rtl/dcr_launch_fsm.sv
// Launch sequencer: IDLE -> COMMIT -> OFFER -> RUN -> IDLE.
// Emits a one-cycle commit strobe, the dispatcher handshake and busy.
module dcr_launch_fsm
    import dcr_pkg::*;
(
    input  logic clk,
    input  logic reset,          // synchronous, active-low
    input  logic launch_req_i,
    input  logic launch_ready_i,
    input  logic kernel_done_i,
    output logic commit_o,
    output logic launch_valid_o,
    output logic busy_o,
    output logic launch_err_o
);

    dcr_state_e state_q;
    dcr_state_e state_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; handshake and done are only honoured in their own state.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch_req_i)   state_d = COMMIT;
            COMMIT:                      state_d = OFFER;
            OFFER:   if (launch_ready_i) state_d = RUN;
            RUN:     if (kernel_done_i)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Moore outputs plus the launch-while-busy error event.
    always_comb begin
        commit_o       = (state_q == COMMIT);
        launch_valid_o = (state_q == OFFER);
        busy_o         = (state_q != IDLE);
        launch_err_o   = launch_req_i && (state_q != IDLE);
    end

endmodule : dcr_launch_fsm

// File: rtl/dcr_bank.sv
// Device control register bank: host-writable shadow registers, committed
// atomically to a frozen active copy on each kernel launch.
module dcr_bank
    import dcr_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,   // synchronous, active-low
    input  logic                         device_control_write_enable,
    input  logic [ADDR_W:0]              device_control_addr,
    input  logic [DATA_W-1:0]            device_control_data,
    input  logic                         rd_active,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         launch_req,
    output logic                         launch_valid,
    input  logic                         launch_ready,
    input  logic                         kernel_done,
    output logic                         busy,
    output logic [NUM_REGS*DATA_W-1:0]   active_regs,
    output logic [DATA_W-1:0]            thread_count,
    output logic [ERR_W-1:0]             err,
    input  logic                         err_clr
);

    // Register count expressed in the address width for a width-matched compare.
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;

    logic              addr_ok;
    logic [ADDR_W-1:0] addr_idx;
    logic              commit;
    logic              launch_err;

    // The extra address MSB lets us see addresses past the last register.
    assign addr_ok  = (device_control_addr < NUM_REGS_A);
    assign addr_idx = device_control_addr[ADDR_W-1:0];

    dcr_launch_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .launch_req_i   (launch_req),
        .launch_ready_i (launch_ready),
        .kernel_done_i  (kernel_done),
        .commit_o       (commit),
        .launch_valid_o (launch_valid),
        .busy_o         (busy),
        .launch_err_o   (launch_err)
    );

    // Shadow update: in-range host writes land in every state.
    always_comb begin
        shadow_d = shadow_q;
        if (device_control_write_enable && addr_ok) begin
            shadow_d[addr_idx] = device_control_data;
        end
    end

    // Active copy: snapshot of the pre-edge shadow on the commit cycle, frozen otherwise.
    // A write in the commit cycle therefore only reaches the next launch.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = shadow_q;
        end
    end

    // Read mux: shadow or active copy; out-of-range addresses read as zero.
    always_comb begin
        rd_data_d = '0;
        if (addr_ok) begin
            rd_data_d = rd_active ? active_q[addr_idx] : shadow_q[addr_idx];
        end
    end

    // Sticky errors: clear first, then new events, so a same-cycle set wins.
    always_comb begin
        err_d = err_clr ? '0 : err_q;
        if (device_control_write_enable && !addr_ok) begin
            err_d[ERR_ADDR] = 1'b1;
        end
        if (launch_err) begin
            err_d[ERR_LAUNCH] = 1'b1;
        end
    end

    // Register file, read data and error flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: both register arrays are reset because their zero state is visible to host and dispatcher.
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            rd_data_q <= '0;
            err_q     <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // Flatten the active copy: register i at bits [i*DATA_W +: DATA_W].
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign active_regs[i*DATA_W +: DATA_W] = active_q[i];
    end

    assign thread_count = active_q[0];
    assign rd_data      = rd_data_q;
    assign err          = err_q;

endmodule : dcr_bank

// File: tb/tb_dcr_bank.sv
// Directed self-checking bench for dcr_bank (NUM_REGS=4, DATA_W=8).
module tb_dcr_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic        rd_active;
    logic [7:0]  rd_data;
    logic        launch_req;
    logic        launch_valid;
    logic        launch_ready;
    logic        kernel_done;
    logic        busy;
    logic [31:0] active_regs;
    logic [7:0]  thread_count;
    logic [1:0]  err;
    logic        err_clr;

    int n_cmp = 0;
    int n_err = 0;

    dcr_bank #(.NUM_REGS(4), .DATA_W(8)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .device_control_write_enable (we),
        .device_control_addr         (addr),
        .device_control_data         (wdata),
        .rd_active                   (rd_active),
        .rd_data                     (rd_data),
        .launch_req                  (launch_req),
        .launch_valid                (launch_valid),
        .launch_ready                (launch_ready),
        .kernel_done                 (kernel_done),
        .busy                        (busy),
        .active_regs                 (active_regs),
        .thread_count                (thread_count),
        .err                         (err),
        .err_clr                     (err_clr)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = '0; wdata = '0; rd_active = 1'b0;
        launch_req = 1'b0; launch_ready = 1'b0; kernel_done = 1'b0; err_clr = 1'b0;

        // Reset with all inputs idle.
        tick(); tick();
        check("rst_thread_count", 32'(thread_count), 32'h00);
        check("rst_busy",         32'(busy),         32'h0);
        check("rst_valid",        32'(launch_valid), 32'h0);
        check("rst_err",          32'(err),          32'h0);
        check("rst_active",       active_regs,       32'h0);
        reset = 1'b1;

        // Shadow writes and shadow reads.
        we = 1'b1; addr = 3'd0; wdata = 8'h55; tick();
        addr = 3'd1; wdata = 8'h10; tick();
        we = 1'b0; rd_active = 1'b0; addr = 3'd0; tick();
        check("rd_shadow0", 32'(rd_data), 32'h55);
        addr = 3'd1; tick();
        check("rd_shadow1", 32'(rd_data), 32'h10);
        check("tc_before_launch", 32'(thread_count), 32'h00);

        // Launch with ready tied high.
        launch_ready = 1'b1; launch_req = 1'b1; tick();
        launch_req = 1'b0;
        check("commit_busy",  32'(busy),         32'h1);
        check("commit_valid", 32'(launch_valid), 32'h0);
        check("commit_tc",    32'(thread_count), 32'h00);
        tick();
        check("offer_tc",     32'(thread_count), 32'h55);
        check("offer_active", active_regs,       32'h0000_1055);
        check("offer_valid",  32'(launch_valid), 32'h1);
        tick();
        check("run_valid",    32'(launch_valid), 32'h0);
        check("run_busy",     32'(busy),         32'h1);
        launch_ready = 1'b0;

        // Write during RUN reaches the shadow only.
        we = 1'b1; addr = 3'd0; wdata = 8'h77; tick();
        we = 1'b0; tick();
        check("run_rd_shadow", 32'(rd_data),      32'h77);
        check("run_tc_frozen", 32'(thread_count), 32'h55);
        rd_active = 1'b1; tick();
        check("run_rd_active", 32'(rd_data), 32'h55);
        kernel_done = 1'b1; tick();
        kernel_done = 1'b0;
        check("done_busy", 32'(busy),         32'h0);
        check("done_tc",   32'(thread_count), 32'h55);

        // Relaunch with ready held low in OFFER.
        launch_req = 1'b1; tick();
        launch_req = 1'b0; tick();
        check("relaunch_tc",    32'(thread_count), 32'h77);
        check("relaunch_valid", 32'(launch_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            launch_req  = (i == 2);
            kernel_done = (i == 3);
            tick();
            check("hold_valid",  32'(launch_valid), 32'h1);
            check("hold_active", active_regs,       32'h0000_1077);
            check("hold_err",    32'(err),          (i >= 2) ? 32'h2 : 32'h0);
        end
        launch_req = 1'b0;

        // Handshake with a same-cycle done, which must be ignored.
        launch_ready = 1'b1; kernel_done = 1'b1; tick();
        launch_ready = 1'b0; kernel_done = 1'b0;
        check("hs_valid", 32'(launch_valid), 32'h0);
        check("hs_busy",  32'(busy),         32'h1);
        tick();
        check("hs_still_run", 32'(busy), 32'h1);
        kernel_done = 1'b1; tick();
        kernel_done = 1'b0;
        check("hs_done_idle", 32'(busy), 32'h0);

        // Out-of-range write: dropped, flagged; err_clr behaviour.
        we = 1'b1; addr = 3'd4; wdata = 8'hAA; rd_active = 1'b0; tick();
        we = 1'b0;
        check("oor_err",    32'(err),    32'h3);
        check("oor_active", active_regs, 32'h0000_1077);
        tick();
        check("oor_rd_zero", 32'(rd_data), 32'h00);
        addr = 3'd0; tick();
        check("oor_no_alias0", 32'(rd_data), 32'h77);
        addr = 3'd1; tick();
        check("oor_no_alias1", 32'(rd_data), 32'h10);
        err_clr = 1'b1; we = 1'b1; addr = 3'd5; tick();
        we = 1'b0;
        check("clr_set_wins", 32'(err), 32'h1);
        tick();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 32'h0);

        // Write with launch_req, then write during COMMIT.
        we = 1'b1; addr = 3'd0; wdata = 8'h22; launch_req = 1'b1; launch_ready = 1'b1; tick();
        launch_req = 1'b0; wdata = 8'h33; tick();
        we = 1'b0;
        check("wcommit_tc",     32'(thread_count), 32'h22);
        check("wcommit_valid",  32'(launch_valid), 32'h1);
        check("wcommit_active", active_regs,       32'h0000_1022);
        tick();
        launch_ready = 1'b0;
        check("wcommit_run_valid", 32'(launch_valid), 32'h0);
        rd_active = 1'b0; addr = 3'd0; tick();
        check("wcommit_shadow", 32'(rd_data), 32'h33);
        rd_active = 1'b1; tick();
        check("wcommit_active_rd", 32'(rd_data), 32'h22);

        // Reset while in RUN.
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b0; tick();
        check("rrun_busy",   32'(busy),         32'h0);
        check("rrun_valid",  32'(launch_valid), 32'h0);
        check("rrun_tc",     32'(thread_count), 32'h00);
        check("rrun_active", active_regs,       32'h0);
        check("rrun_rd",     32'(rd_data),      32'h00);
        reset = 1'b1; rd_active = 1'b0; addr = 3'd0; tick();
        check("rrun_shadow0", 32'(rd_data), 32'h00);
        addr = 3'd1; tick();
        check("rrun_shadow1", 32'(rd_data), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dcr_bank
